fifo_rd_stream: RTL and testbench

//  Read-side consumer for async_fifo, clocked in the read domain.

---
 rtl/fifo_rd_stream.sv | 118 +++++++++++
 tb/tb_fifo_rd_stream.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
// Read-domain consumer for an async FIFO.
// Pops into a 2-entry buffer and presents a valid/ready stream with burst tags.
module fifo_rd_stream #(
    parameter int DATA_SIZE = 8,
    parameter int BURST_LEN = 4,
    parameter int SAFE_GAP  = 1,
    parameter int CNT_W     = 16
) (
    input  logic                 rd_clk,
    input  logic                 rrst,
    input  logic                 enable,
    input  logic                 fifo_empty,
    input  logic [DATA_SIZE-1:0] fifo_data,
    output logic                 fifo_rd_en,
    output logic [DATA_SIZE-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 m_last,
    output logic [CNT_W-1:0]     word_cnt,
    output logic                 busy
);

    localparam int BI_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BI_W-1:0] BI_LAST = BI_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        TWO
    } occ_t;

    occ_t state, state_nx;

    logic                 gap;
    logic [BI_W-1:0]      burst_idx;
    logic [DATA_SIZE-1:0] h_data, t_data;
    logic                 h_last, t_last;
    logic                 pop, xfer, new_last;
    logic                 to_head, to_tail, shift;

    // Pop is held off while in reset so the FIFO never loses a word.
    assign pop = rrst & enable & ~fifo_empty
               & (state != TWO) & ~gap;

    assign m_valid    = (state != EMPTY);
    assign xfer       = m_valid & m_ready;
    assign new_last   = (burst_idx == BI_LAST);
    assign fifo_rd_en = pop;
    assign busy       = m_valid | pop;
    assign m_data     = h_data;
    assign m_last     = h_last;

    // A new word lands in head when the buffer is (or becomes) empty of it.
    assign to_head = pop & ((state == EMPTY) | ((state == ONE) & xfer));
    assign to_tail = pop & (state == ONE) & ~xfer;
    assign shift   = (state == TWO) & xfer;

    // Occupancy state register.
    always_ff @(posedge rd_clk or negedge rrst) begin
        if (!rrst) state <= EMPTY;
        else       state <= state_nx;
    end

    // Occupancy next-state.
    always_comb begin
        state_nx = state;
        unique case (state)
            EMPTY: if (pop) state_nx = ONE;
            ONE: begin
                if (pop && !xfer)      state_nx = TWO;
                else if (xfer && !pop) state_nx = EMPTY;
            end
            TWO:     if (xfer) state_nx = ONE;
            default: state_nx = EMPTY;
        endcase
    end

    // Head/tail storage; tail moves to head when head is consumed at occ=2.
    always_ff @(posedge rd_clk or negedge rrst) begin
        if (!rrst) begin
            h_data <= '0;
            h_last <= 1'b0;
            t_data <= '0;
            t_last <= 1'b0;
        end else begin
            if (to_head) begin
                h_data <= fifo_data;
                h_last <= new_last;
            end else if (shift) begin
                h_data <= t_data;
                h_last <= t_last;
            end
            if (to_tail) begin
                t_data <= fifo_data;
                t_last <= new_last;
            end
        end
    end

    // Idle cycle after each pop hides the registered-empty lag.
    always_ff @(posedge rd_clk or negedge rrst) begin
        if (!rrst) gap <= 1'b0;
        else       gap <= (SAFE_GAP != 0) ? pop : 1'b0;
    end

    // Burst position of the next popped word.
    always_ff @(posedge rd_clk or negedge rrst) begin
        if (!rrst)    burst_idx <= '0;
        else if (pop) burst_idx <= new_last ? '0 : burst_idx + 1'b1;
    end

    // Completed output transfers, wrapping.
    always_ff @(posedge rd_clk or negedge rrst) begin
        if (!rrst)     word_cnt <= '0;
        else if (xfer) word_cnt <= word_cnt + 1'b1;
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream.
// Table-driven cycle trace plus queue-fed multi-cycle sequences.
module tb_fifo_rd_stream;

    localparam bit H = 1'b1;
    localparam bit L = 1'b0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rrst, enable, m_ready;
    logic        fifo_empty, fifo_empty0;
    logic [7:0]  fifo_data, fifo_data0;
    logic        fifo_rd_en, fifo_rd_en0;
    logic [7:0]  m_data, m_data0;
    logic        m_valid, m_valid0, m_last, m_last0, busy, busy0;
    logic [15:0] word_cnt, word_cnt0;

    fifo_rd_stream #(.DATA_SIZE(8), .BURST_LEN(4), .SAFE_GAP(1), .CNT_W(16)) dut (
        .rd_clk(clk), .rrst(rrst), .enable(enable),
        .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_rd_en(fifo_rd_en), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .m_last(m_last), .word_cnt(word_cnt), .busy(busy)
    );

    fifo_rd_stream #(.DATA_SIZE(8), .BURST_LEN(4), .SAFE_GAP(0), .CNT_W(16)) dut0 (
        .rd_clk(clk), .rrst(rrst), .enable(enable),
        .fifo_empty(fifo_empty0), .fifo_data(fifo_data0),
        .fifo_rd_en(fifo_rd_en0), .m_data(m_data0), .m_valid(m_valid0),
        .m_ready(m_ready), .m_last(m_last0), .word_cnt(word_cnt0), .busy(busy0)
    );

    typedef struct {
        bit       en;
        bit       emp;
        bit [7:0] d;
        bit       rdy;
        bit       rd;
        bit       v;
        bit [7:0] md;
        bit       ml;
        bit       bz;
    } vec_t;

    vec_t tv[$];

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] q[$], q0[$], got[$], got0[$];
    bit         gotl[$];
    int         pops, adj, pops0, run0, maxrun0;
    bit         prev_rd;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    task automatic addv(input bit en, input bit emp, input bit [7:0] d,
                        input bit rdy, input bit rd, input bit v,
                        input bit [7:0] md, input bit ml, input bit bz);
        vec_t r;
        r.en = en; r.emp = emp; r.d = d; r.rdy = rdy;
        r.rd = rd; r.v = v; r.md = md; r.ml = ml; r.bz = bz;
        tv.push_back(r);
    endtask

    task automatic upd();
        fifo_empty  = (q.size() == 0);
        fifo_data   = (q.size() != 0) ? q[0] : 8'h00;
        fifo_empty0 = (q0.size() == 0);
        fifo_data0  = (q0.size() != 0) ? q0[0] : 8'h00;
    endtask

    task automatic clr();
        pops = 0; adj = 0; pops0 = 0; run0 = 0; maxrun0 = 0; prev_rd = 1'b0;
        got.delete(); gotl.delete(); got0.delete();
    endtask

    // Called just after a negedge with inputs settled; ends at the next negedge.
    task automatic cyc();
        bit r, r0, x, x0;
        #1;
        r  = fifo_rd_en;
        r0 = fifo_rd_en0;
        x  = m_valid & m_ready;
        x0 = m_valid0 & m_ready;
        if (r) begin
            pops++;
            if (prev_rd) adj++;
        end
        prev_rd = r;
        if (r0) begin
            pops0++;
            run0++;
            if (run0 > maxrun0) maxrun0 = run0;
        end else begin
            run0 = 0;
        end
        if (x) begin
            got.push_back(m_data);
            gotl.push_back(m_last);
        end
        if (x0) got0.push_back(m_data0);
        @(posedge clk);
        #1;
        if (r && q.size() != 0) void'(q.pop_front());
        if (r0 && q0.size() != 0) void'(q0.pop_front());
        upd();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rrst = 1'b0;
        q.delete();
        q0.delete();
        upd();
        clr();
        @(negedge clk);
        rrst = 1'b1;
    endtask

    initial begin
        rrst        = 1'b0;
        enable      = 1'b1;
        m_ready     = 1'b0;
        fifo_empty  = 1'b0;
        fifo_data   = 8'h5A;
        fifo_empty0 = 1'b1;
        fifo_data0  = 8'h00;
        clr();

        repeat (2) @(negedge clk);
        #1;
        chk("rst_rd_en", 32'(fifo_rd_en), 32'(0));
        chk("rst_valid", 32'(m_valid), 32'(0));
        chk("rst_last", 32'(m_last), 32'(0));
        chk("rst_data", 32'(m_data), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_cnt", 32'(word_cnt), 32'(0));

        addv(H, L, 8'h11, L, H, L, 8'h00, L, H);
        addv(H, L, 8'h22, L, L, H, 8'h11, L, H);
        addv(H, L, 8'h22, L, H, H, 8'h11, L, H);
        addv(H, L, 8'h33, L, L, H, 8'h11, L, H);
        addv(H, L, 8'h33, L, L, H, 8'h11, L, H);
        addv(H, L, 8'h33, H, L, H, 8'h11, L, H);
        addv(H, L, 8'h33, H, H, H, 8'h22, L, H);
        addv(H, L, 8'h44, L, L, H, 8'h33, L, H);
        addv(H, L, 8'h44, H, H, H, 8'h33, L, H);
        addv(L, L, 8'h55, H, L, H, 8'h44, H, H);
        addv(L, L, 8'h55, H, L, L, 8'h00, L, L);
        addv(H, H, 8'h00, H, L, L, 8'h00, L, L);
        addv(H, L, 8'h66, H, H, L, 8'h00, L, H);
        addv(H, H, 8'h00, H, L, H, 8'h66, L, H);

        rrst = 1'b1;
        foreach (tv[i]) begin
            enable     = tv[i].en;
            fifo_empty = tv[i].emp;
            fifo_data  = tv[i].d;
            m_ready    = tv[i].rdy;
            #1;
            chk($sformatf("tv%0d_rd_en", i), 32'(fifo_rd_en), 32'(tv[i].rd));
            chk($sformatf("tv%0d_valid", i), 32'(m_valid), 32'(tv[i].v));
            chk($sformatf("tv%0d_busy", i), 32'(busy), 32'(tv[i].bz));
            if (tv[i].v) begin
                chk($sformatf("tv%0d_data", i), 32'(m_data), 32'(tv[i].md));
                chk($sformatf("tv%0d_last", i), 32'(m_last), 32'(tv[i].ml));
            end
            @(posedge clk);
            @(negedge clk);
        end
        #1;
        chk("tv_word_cnt", 32'(word_cnt), 32'(5));

        // Backpressure: only two pops fit, head holds word 0.
        do_reset();
        enable  = 1'b1;
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) q.push_back(8'hA0 + 8'(i));
        upd();
        repeat (8) cyc();
        chk("bp_pops", 32'(pops), 32'(2));
        #1;
        chk("bp_rd_idle", 32'(fifo_rd_en), 32'(0));
        chk("bp_head", 32'(m_data), 32'(8'hA0));
        chk("bp_valid", 32'(m_valid), 32'(1));
        m_ready = 1'b1;
        for (int k = 0; k < 40 && got.size() < 5; k++) cyc();
        chk("bp_count", 32'(got.size()), 32'(5));
        for (int i = 0; i < 5 && i < got.size(); i++)
            chk($sformatf("bp_word%0d", i), 32'(got[i]), 32'(8'hA0 + 8'(i)));
        chk("bp_adjacent", 32'(adj), 32'(0));
        chk("bp_word_cnt", 32'(word_cnt), 32'(5));

        // Burst tags over two bursts.
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) q.push_back(8'h30 + 8'(i));
        upd();
        for (int k = 0; k < 40 && got.size() < 8; k++) cyc();
        chk("bl_count", 32'(got.size()), 32'(8));
        for (int i = 0; i < 8 && i < got.size(); i++) begin
            chk($sformatf("bl_word%0d", i), 32'(got[i]), 32'(8'h30 + 8'(i)));
            chk($sformatf("bl_last%0d", i), 32'(gotl[i]), 32'((i == 3) || (i == 7)));
        end
        chk("bl_word_cnt", 32'(word_cnt), 32'(8));
        chk("bl_adjacent", 32'(adj), 32'(0));

        // Gap on vs off, six words each.
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            q.push_back(8'h50 + 8'(i));
            q0.push_back(8'h60 + 8'(i));
        end
        upd();
        for (int k = 0; k < 40 && (got.size() < 6 || got0.size() < 6); k++) cyc();
        chk("g1_pops", 32'(pops), 32'(6));
        chk("g1_adjacent", 32'(adj), 32'(0));
        chk("g0_pops", 32'(pops0), 32'(6));
        chk("g0_run", 32'(maxrun0), 32'(6));
        chk("g0_count", 32'(got0.size()), 32'(6));
        for (int i = 0; i < 6 && i < got0.size(); i++)
            chk($sformatf("g0_word%0d", i), 32'(got0[i]), 32'(8'h60 + 8'(i)));
        chk("g0_word_cnt", 32'(word_cnt0), 32'(6));

        // Enable drop with two buffered words.
        do_reset();
        enable  = 1'b1;
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) q.push_back(8'h70 + 8'(i));
        upd();
        repeat (4) cyc();
        chk("en_fill_pops", 32'(pops), 32'(2));
        enable  = 1'b0;
        m_ready = 1'b1;
        repeat (6) cyc();
        chk("en_drained", 32'(got.size()), 32'(2));
        chk("en_no_pop", 32'(pops), 32'(2));
        #1;
        chk("en_valid", 32'(m_valid), 32'(0));
        chk("en_busy", 32'(busy), 32'(0));
        enable = 1'b1;
        for (int k = 0; k < 30 && got.size() < 4; k++) cyc();
        chk("en_count", 32'(got.size()), 32'(4));
        for (int i = 0; i < 4 && i < got.size(); i++)
            chk($sformatf("en_word%0d", i), 32'(got[i]), 32'(8'h70 + 8'(i)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
